// File: rtl/uart_prog_loader.sv
// uart_prog_loader: assembles a framed UART byte stream into program-memory
// words. Frame = COUNT byte, COUNT*BPW payload bytes, XOR checksum byte.
// Words are written at auto-incremented addresses. The frame ends with a
// one-cycle prog_rdy pulse or a prog_err pulse and an error code.
module uart_prog_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int ADDR_STEP      = 4,
  parameter int BASE_ADDR      = 0,
  parameter int BIG_ENDIAN     = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_valid_i,
  input  logic [BYTE_WIDTH-1:0] rx_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  prog_rdy_o,
  output logic                  prog_err_o,
  output logic [1:0]            err_code_o
);

  localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, RX_WORD, RX_CSUM} state_t;

  state_t                state_q;
  logic [BYTE_WIDTH-1:0] cnt_q;    // words in this frame
  logic [BYTE_WIDTH-1:0] k_q;      // words written so far
  logic [BCW-1:0]        b_q;      // byte lane within current word
  logic [BYTE_WIDTH-1:0] acc_q;    // running XOR checksum
  logic [DATA_WIDTH-1:0] word_q;   // word under assembly
  logic [DATA_WIDTH-1:0] word_d;
  logic [ADDR_WIDTH-1:0] addr_q;   // address of the next write
  logic [IW-1:0]         idle_q;   // cycles since last byte
  logic                  wr_en_q, rdy_q, err_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [1:0]            code_q;

  // Insert the incoming byte into its lane of the word under assembly.
  always_comb begin
    word_d = word_q;
    for (int i = 0; i < BPW; i++) begin
      if (b_q == BCW'(i))
        word_d[((BIG_ENDIAN != 0) ? (BPW-1-i) : i)*BYTE_WIDTH +: BYTE_WIDTH] = rx_data_i;
    end
  end

  // Frame FSM: counters, checksum, timeout and all registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      idle_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      wr_en_q <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (rx_valid_i) begin
            cnt_q   <= rx_data_i;
            acc_q   <= rx_data_i;
            code_q  <= ERR_NONE;
            k_q     <= '0;
            b_q     <= '0;
            addr_q  <= ADDR_WIDTH'(BASE_ADDR);
            state_q <= (rx_data_i != '0) ? RX_WORD : RX_CSUM;
          end
        end
        RX_WORD, RX_CSUM: begin
          // Timeout wins over a byte arriving in the same cycle.
          if (TO_EN && idle_q == IW'(TIMEOUT_CYCLES)) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TOUT;
            state_q <= IDLE;
            acc_q   <= '0;
            word_q  <= '0;
            b_q     <= '0;
            k_q     <= '0;
            idle_q  <= '0;
          end else if (rx_valid_i) begin
            idle_q <= '0;
            if (state_q == RX_WORD) begin
              acc_q  <= acc_q ^ rx_data_i;
              word_q <= word_d;
              if (b_q == BCW'(BPW-1)) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= word_d;
                addr_q    <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                b_q       <= '0;
                k_q       <= k_q + 1'b1;
                if ((k_q + 1'b1) == cnt_q) state_q <= RX_CSUM;
              end else begin
                b_q <= b_q + 1'b1;
              end
            end else begin
              if (rx_data_i == acc_q) begin
                rdy_q <= 1'b1;
              end else begin
                err_q  <= 1'b1;
                code_q <= ERR_CSUM;
              end
              state_q <= IDLE;
            end
          end else if (TO_EN) begin
            idle_q <= idle_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = (state_q != IDLE);
  assign prog_rdy_o = rdy_q;
  assign prog_err_o = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic r; logic e; logic [1:0] c; } ev_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rxv[4];
  logic [7:0]  rxd[4];
  logic        we[4];
  logic [7:0]  wa[4];
  logic [31:0] wd[4];
  logic        bs[4], rdy[4], er[4];
  logic [1:0]  ec[4];

  wr_t wq[4][$];
  ev_t eq[4][$];
  int  ntests = 0;
  int  nfail  = 0;

  always #5 clk = ~clk;

  uart_prog_loader u_def (.clk(clk), .arst_n(arst_n), .rx_valid_i(rxv[0]), .rx_data_i(rxd[0]),
    .wr_en_o(we[0]), .wr_addr_o(wa[0]), .wr_data_o(wd[0]), .busy_o(bs[0]),
    .prog_rdy_o(rdy[0]), .prog_err_o(er[0]), .err_code_o(ec[0]));
  uart_prog_loader #(.BIG_ENDIAN(0)) u_le (.clk(clk), .arst_n(arst_n), .rx_valid_i(rxv[1]), .rx_data_i(rxd[1]),
    .wr_en_o(we[1]), .wr_addr_o(wa[1]), .wr_data_o(wd[1]), .busy_o(bs[1]),
    .prog_rdy_o(rdy[1]), .prog_err_o(er[1]), .err_code_o(ec[1]));
  uart_prog_loader #(.TIMEOUT_CYCLES(100)) u_to (.clk(clk), .arst_n(arst_n), .rx_valid_i(rxv[2]), .rx_data_i(rxd[2]),
    .wr_en_o(we[2]), .wr_addr_o(wa[2]), .wr_data_o(wd[2]), .busy_o(bs[2]),
    .prog_rdy_o(rdy[2]), .prog_err_o(er[2]), .err_code_o(ec[2]));
  uart_prog_loader #(.BASE_ADDR(8'hFC)) u_wr (.clk(clk), .arst_n(arst_n), .rx_valid_i(rxv[3]), .rx_data_i(rxd[3]),
    .wr_en_o(we[3]), .wr_addr_o(wa[3]), .wr_data_o(wd[3]), .busy_o(bs[3]),
    .prog_rdy_o(rdy[3]), .prog_err_o(er[3]), .err_code_o(ec[3]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (we[d] === 1'b1) begin
        ntests++;
        if (wq[d].size() == 0) begin
          nfail++;
          $error("FAIL wr_expected: unexpected write on %0d", d);
        end else begin
          wr_t w;
          w = wq[d].pop_front();
          ntests++;
          if (wa[d] !== w.a) begin
            nfail++;
            $error("FAIL wr_addr: observed %0h expected %0h", wa[d], w.a);
          end
          ntests++;
          if (wd[d] !== w.d) begin
            nfail++;
            $error("FAIL wr_data: observed %0h expected %0h", wd[d], w.d);
          end
        end
      end
      if (rdy[d] === 1'b1 || er[d] === 1'b1) begin
        ntests++;
        if ((rdy[d] & er[d]) !== 1'b0) begin
          nfail++;
          $error("FAIL rdy_err_exclusive on %0d", d);
        end
        ntests++;
        if (eq[d].size() == 0) begin
          nfail++;
          $error("FAIL ev_expected: unexpected event on %0d", d);
        end else begin
          ev_t e;
          e = eq[d].pop_front();
          ntests++;
          if (rdy[d] !== e.r) begin
            nfail++;
            $error("FAIL prog_rdy: observed %0h expected %0h", rdy[d], e.r);
          end
          ntests++;
          if (er[d] !== e.e) begin
            nfail++;
            $error("FAIL prog_err: observed %0h expected %0h", er[d], e.e);
          end
          ntests++;
          if (ec[d] !== e.c) begin
            nfail++;
            $error("FAIL err_code: observed %0h expected %0h", ec[d], e.c);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    rxv[d] = 1'b1;
    rxd[d] = b;
    @(posedge clk);
    #1;
    rxv[d] = 1'b0;
  endtask

  task automatic send_bytes(input int d, input bq_t bq);
    foreach (bq[i]) send_byte(d, bq[i]);
  endtask

  task automatic push_wr(input int d, input logic [7:0] a, input logic [31:0] v);
    wr_t w;
    w.a = a; w.d = v;
    wq[d].push_back(w);
  endtask

  task automatic push_ev(input int d, input logic r, input logic e, input logic [1:0] c);
    ev_t x;
    x.r = r; x.e = e; x.c = c;
    eq[d].push_back(x);
  endtask

  task automatic drained(input int d);
    chk("wr_queue_drained", wq[d].size(), 0);
    chk("ev_queue_drained", eq[d].size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bq;
    int  n;
    for (int d = 0; d < 4; d++) begin rxv[d] = 1'b0; rxd[d] = 8'h00; end
    #12;
    for (int d = 0; d < 4; d++)
      chk("reset_outputs", {we[d], wa[d], wd[d], bs[d], rdy[d], er[d], ec[d]}, 46'h0);
    arst_n = 1'b1;
    tick(2);

    push_wr(0, 8'h00, 32'h11223344);
    push_wr(0, 8'h04, 32'hAABBCCDD);
    push_ev(0, 1'b1, 1'b0, 2'b00);
    bq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(0, bq);
    chk("wr_latency", we[0], 1'b1);
    chk("busy_mid_frame", bs[0], 1'b1);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    send_bytes(0, bq);
    chk("rdy_latency", rdy[0], 1'b1);
    chk("busy_low_at_rdy", bs[0], 1'b0);
    tick(2);
    chk("err_code_good", ec[0], 2'b00);
    chk("wr_data_held", wd[0], 32'hAABBCCDD);
    drained(0);

    push_wr(0, 8'h00, 32'h11223344);
    push_wr(0, 8'h04, 32'hAABBCCDD);
    push_ev(0, 1'b0, 1'b1, 2'b01);
    bq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
    send_bytes(0, bq);
    tick(3);
    chk("err_code_csum_held", ec[0], 2'b01);
    drained(0);

    push_wr(0, 8'h00, 32'h11223344);
    push_wr(0, 8'h04, 32'hAABBCCDD);
    push_ev(0, 1'b1, 1'b0, 2'b00);
    bq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    send_bytes(0, bq);
    tick(2);
    chk("err_code_cleared", ec[0], 2'b00);

    push_ev(0, 1'b1, 1'b0, 2'b00);
    bq = '{8'h00, 8'h00};
    send_bytes(0, bq);
    tick(2);
    push_ev(0, 1'b0, 1'b1, 2'b01);
    bq = '{8'h00, 8'h01};
    send_bytes(0, bq);
    tick(2);
    chk("err_code_count0", ec[0], 2'b01);
    drained(0);

    push_wr(1, 8'h00, 32'h44332211);
    push_ev(1, 1'b1, 1'b0, 2'b00);
    bq = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_bytes(1, bq);
    tick(2);
    drained(1);

    tick(150);
    drained(2);
    push_ev(2, 1'b0, 1'b1, 2'b10);
    bq = '{8'h01, 8'h11, 8'h22};
    send_bytes(2, bq);
    n = 0;
    while (er[2] !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk("timeout_cycle", n, 101);
    chk("timeout_busy_low", bs[2], 1'b0);
    tick(2);
    chk("timeout_code_held", ec[2], 2'b10);
    drained(2);
    push_wr(2, 8'h00, 32'hDEADBEEF);
    push_ev(2, 1'b1, 1'b0, 2'b00);
    bq = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    foreach (bq[i]) begin
      send_byte(2, bq[i]);
      if (i != bq.size() - 1) tick(99);
    end
    tick(2);
    chk("timeout_recovered_code", ec[2], 2'b00);
    drained(2);

    push_wr(3, 8'hFC, 32'h01020304);
    push_wr(3, 8'h00, 32'h05060708);
    push_ev(3, 1'b1, 1'b0, 2'b00);
    bq = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    send_bytes(3, bq);
    tick(2);
    drained(3);

    bq = '{8'h01, 8'hAA, 8'hBB};
    send_bytes(3, bq);
    chk("busy_before_reset", bs[3], 1'b1);
    arst_n = 1'b0;
    #2;
    chk("rst_mid_outputs", {we[3], wa[3], wd[3], bs[3], rdy[3], er[3], ec[3]}, 46'h0);
    arst_n = 1'b1;
    tick(2);
    push_wr(3, 8'hFC, 32'hCAFEBABE);
    push_ev(3, 1'b1, 1'b0, 2'b00);
    bq = '{8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31};
    send_bytes(3, bq);
    tick(3);
    for (int d = 0; d < 4; d++) drained(d);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
